// File: rtl/seg_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : seg_lfsr_checker
// Description : Receive-side checker for a two-digit seven-segment LFSR
//               display. Decodes active-low seg1/seg0 patterns to a byte on
//               each step strobe, tracks the 8-bit LFSR sequence, and
//               reports lock, sequence errors and illegal patterns.
// Options     : SEG_DP_CHECK_EN - when defined, a lit decimal point on either
//               digit makes the sample illegal; otherwise dp is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_lfsr_checker #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [7:0]       seg1,
  input  logic [7:0]       seg0,
  input  logic             clr,
  output logic [7:0]       value,
  output logic             valid,
  output logic             illegal,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [0:0]       c_unlocked  = 1'b0;
  localparam logic [0:0]       c_locked    = 1'b1;
  localparam logic [3:0]       c_lock_last = 4'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] c_err_max   = '1;

  // Returns {legal, nibble}. The dp bit is forced off so only a..g matter.
  function automatic logic [4:0] seg_decode(input logic [7:0] pat);
    logic [4:0] res;
    res = 5'b1_0000;
    case (pat | 8'h01)
      8'h03:   res[3:0] = 4'h0;
      8'h9F:   res[3:0] = 4'h1;
      8'h25:   res[3:0] = 4'h2;
      8'h0D:   res[3:0] = 4'h3;
      8'h99:   res[3:0] = 4'h4;
      8'h49:   res[3:0] = 4'h5;
      8'h41:   res[3:0] = 4'h6;
      8'h1F:   res[3:0] = 4'h7;
      8'h01:   res[3:0] = 4'h8;
      8'h09:   res[3:0] = 4'h9;
      8'h11:   res[3:0] = 4'hA;
      8'hC1:   res[3:0] = 4'hB;
      8'h63:   res[3:0] = 4'hC;
      8'h85:   res[3:0] = 4'hD;
      8'h61:   res[3:0] = 4'hE;
      8'h71:   res[3:0] = 4'hF;
      default: res      = 5'b0_0000;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
  endfunction

  logic [4:0] w_dec1;
  logic [4:0] w_dec0;
  logic       w_dp_ok;
  logic       w_legal;
  logic [7:0] w_decoded;
  logic [7:0] w_exp;
  logic       w_hit;
  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic [7:0] r_prev;
  logic       r_seeded;
  logic [3:0] r_match_cnt;
  logic [3:0] w_match_nxt;
  logic       w_err_nxt;

  assign w_dec1    = seg_decode(seg1);
  assign w_dec0    = seg_decode(seg0);
`ifdef SEG_DP_CHECK_EN
  assign w_dp_ok   = seg1[0] & seg0[0];
`else
  assign w_dp_ok   = 1'b1;
`endif
  assign w_legal   = w_dec1[4] & w_dec0[4] & w_dp_ok;
  assign w_decoded = {w_dec1[3:0], w_dec0[3:0]};
  // A zero history cannot advance the LFSR, so it restarts at 01.
  assign w_exp     = (r_prev == 8'h00) ? 8'h01 : lfsr_next(r_prev);
  assign w_hit     = w_legal && r_seeded && (w_decoded == w_exp);
  assign locked    = (r_state == c_locked);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_unlocked;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: lock after enough consecutive hits, drop on any miss.
  always_comb begin
    w_state_nxt = r_state;
    if (step) begin
      case (r_state)
        c_unlocked: if (w_hit && (r_match_cnt == c_lock_last)) w_state_nxt = c_locked;
        c_locked:   if (!w_hit) w_state_nxt = c_unlocked;
        default:    w_state_nxt = c_unlocked;
      endcase
    end
  end

  // Output logic: hit counter update and error pulse; errors only while locked.
  always_comb begin
    w_match_nxt = r_match_cnt;
    w_err_nxt   = 1'b0;
    if (step) begin
      case (r_state)
        c_unlocked: begin
          if (!r_seeded && w_legal) begin
            // first legal sample only seeds the history
            w_match_nxt = 4'd0;
          end else if (w_hit) begin
            w_match_nxt = (r_match_cnt == c_lock_last) ? 4'd0 : r_match_cnt + 4'(1);
          end else begin
            w_match_nxt = 4'd0;
          end
        end
        c_locked: begin
          if (!w_hit) begin
            w_err_nxt   = 1'b1;
            w_match_nxt = 4'd0;
          end
        end
        default: w_match_nxt = 4'd0;
      endcase
    end
  end

  // Sample registers: pulses follow step; only legal samples move value/history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt <= 4'd0;
      r_prev      <= 8'h00;
      r_seeded    <= 1'b0;
      value       <= 8'h00;
      valid       <= 1'b0;
      illegal     <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_match_cnt <= w_match_nxt;
      valid       <= step;
      illegal     <= step & ~w_legal;
      err         <= w_err_nxt;
      if (step && w_legal) begin
        value    <= w_decoded;
        r_prev   <= w_decoded;
        r_seeded <= 1'b1;
      end
    end
  end

  // Saturating error counter; clear takes priority over a coincident error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (w_err_nxt && (err_cnt != c_err_max)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_lfsr_checker
// Description : Self-checking bench for seg_lfsr_checker; directed sequences
//               plus random stimulus against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_lfsr_checker;

  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;
  localparam logic [7:0] PAT [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                      8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  logic             clk;
  logic             rst_n;
  logic             step;
  logic [7:0]       seg1;
  logic [7:0]       seg0;
  logic             clr;
  logic [7:0]       value;
  logic             valid;
  logic             illegal;
  logic             err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  int n_vec;
  int n_mis;

  // reference model state
  int m_prev, m_value, m_errcnt, m_run;
  bit m_seeded, m_locked, m_valid, m_illegal, m_err;

  seg_lfsr_checker #(.LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .step(step), .seg1(seg1), .seg0(seg0), .clr(clr),
    .value(value), .valid(valid), .illegal(illegal), .err(err), .locked(locked),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lfsr_ref(input int v);
    int fb;
    fb = ((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 1;
    return (fb << 7) | (v >> 1);
  endfunction

  function automatic int exp_of(input int prev);
    return (prev == 0) ? 1 : lfsr_ref(prev);
  endfunction

  // Nibble for a pattern, or -1 when it is not a digit.
  function automatic int nib_of(input logic [7:0] p);
`ifdef SEG_DP_CHECK_EN
    if (p[0] == 1'b0) return -1;
`endif
    for (int i = 0; i < 16; i++) if (PAT[i] == (p | 8'h01)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_value = 0; m_errcnt = 0; m_run = 0;
    m_seeded = 0; m_locked = 0; m_valid = 0; m_illegal = 0; m_err = 0;
  endtask

  task automatic model_step(input bit st, input logic [7:0] s1, input logic [7:0] s0, input bit cl);
    int h, l, dec;
    bit legal, hit;
    m_valid = st; m_illegal = 0; m_err = 0;
    if (st) begin
      h = nib_of(s1);
      l = nib_of(s0);
      legal = (h >= 0) && (l >= 0);
      dec = legal ? h * 16 + l : 0;
      m_illegal = !legal;
      if (legal && !m_seeded) begin
        m_seeded = 1;
        m_run = 0;
      end else begin
        hit = legal && (dec == exp_of(m_prev));
        if (m_locked) begin
          if (!hit) begin m_err = 1; m_locked = 0; m_run = 0; end
        end else if (hit) begin
          m_run++;
          if (m_run >= LOCK_CNT) begin m_locked = 1; m_run = 0; end
        end else begin
          m_run = 0;
        end
      end
      if (legal) begin m_prev = dec; m_value = dec; end
    end
    if (cl) m_errcnt = 0;
    else if (m_err && m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
  endtask

  task automatic check_all();
    chk("value",   32'(value),   32'(m_value));
    chk("valid",   32'(valid),   32'(m_valid));
    chk("illegal", 32'(illegal), 32'(m_illegal));
    chk("err",     32'(err),     32'(m_err));
    chk("locked",  32'(locked),  32'(m_locked));
    chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
  endtask

  task automatic cycle(input bit st, input logic [7:0] s1, input logic [7:0] s0, input bit cl);
    @(negedge clk);
    step = st; seg1 = s1; seg0 = s0; clr = cl;
    @(posedge clk);
    model_step(st, s1, s0, cl);
    #1;
    check_all();
  endtask

  task automatic send_val(input int v, input bit cl);
    logic [7:0] b;
    b = 8'(v);
    cycle(1'b1, PAT[b[7:4]], PAT[b[3:0]], cl);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    step = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int v, r;
    bit st, cl;
    logic [7:0] s1, s0;
    n_vec = 0; n_mis = 0;
    rst_n = 1'b0; step = 1'b0; seg1 = 8'hFF; seg0 = 8'hFF; clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // seed, then two hits to lock: 01 -> 80 -> 40
    send_val(8'h01, 0);
    send_val(8'h80, 0);
    send_val(8'h40, 0);
    // locked run, idle cycle, then a mismatch and an illegal digit
    send_val(8'h20, 0);
    cycle(1'b0, 8'h03, 8'h03, 0);
    send_val(8'h10, 0);
    send_val(8'h88, 0);
    send_val(8'h55, 0);
    send_val(exp_of(m_prev), 0);
    send_val(exp_of(m_prev), 0);
    cycle(1'b1, 8'h03, 8'hFF, 0);
    cycle(1'b1, 8'h03, 8'hFF, 0);

    // drive the error counter into saturation and hold it there
    for (int i = 0; i < 262; i++) begin
      send_val(exp_of(m_prev), 0);
      send_val(exp_of(m_prev), 0);
      send_val(exp_of(m_prev) ^ 1, 0);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
    // clear coincident with an error
    send_val(exp_of(m_prev), 0);
    send_val(exp_of(m_prev), 0);
    send_val(exp_of(m_prev) ^ 1, 1);

    // reset while locked, then the decimal-point sample
    send_val(exp_of(m_prev), 0);
    send_val(exp_of(m_prev), 0);
    async_reset();
    cycle(1'b1, 8'h02, 8'h9F, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r  = int'($urandom_range(0, 99));
      cl = ($urandom_range(0, 29) == 0);
      st = (r < 93);
      if (r < 65) v = exp_of(m_prev);
      else        v = int'($urandom_range(0, 255));
      s1 = PAT[v[7:4]];
      s0 = PAT[v[3:0]];
      if (r >= 80 && r < 90) s0 = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) s1[0] = 1'b0;
      cycle(st, s1, s0, cl);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
